// File: rtl/button_pkg.sv
// Shared types and default timing constants for the push-button conditioning path.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int DEBOUNCE_50MHZ_10MS   = 500000;
    localparam int REPEAT_DELAY_DEFAULT  = 25000000;
    localparam int REPEAT_PERIOD_DEFAULT = 10000000;

    // Maps the synchronized pin onto "1 = pressed" regardless of board wiring.
    function automatic logic normalize_btn(input logic pin, input logic active_low);
        return active_low ? ~pin : pin;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; RESET_VAL is the level loaded on reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces one raw push-button into a clean level and a one-cycle press pulse.
// Define AUTO_REPEAT_EN to add hold-to-repeat pulses while the button stays held.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_10MS,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic button_raw,
    output logic pressed,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic RELEASED_LEVEL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    // Repeat parameters are range-checked even in builds that ignore them.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic       pin_sync;
    logic       btn;
    btn_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       pressed_q;
    logic       pulse_q;
    logic       accept_press;
    logic       rep_fire;

    sync_2ff #(
        .RESET_VAL (RELEASED_LEVEL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (button_raw),
        .q_o   (pin_sync)
    );

    assign btn = normalize_btn(pin_sync, ACTIVE_LOW != 0);

    // Any state change or disagreeing sample leaves cnt_d at its zero default.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (btn) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!btn)                  state_d = IDLE;
                else if (cnt_q == CNT_LAST) state_d = HELD;
                else                       cnt_d   = cnt_q + CNT_W'(1);
            end
            HELD: begin
                if (!btn) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (btn)                   state_d = HELD;
                else if (cnt_q == CNT_LAST) state_d = IDLE;
                else                       cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept_press = (state_q == PRESS_WAIT) && (state_d == HELD);

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_armed_q, rep_armed_d;

    // Release bounce (HELD <-> RELEASE_WAIT) freezes the count instead of clearing it.
    always_comb begin
        rep_d       = rep_q;
        rep_armed_d = rep_armed_q;
        rep_fire    = 1'b0;
        if (accept_press || state_d == IDLE) begin
            rep_d       = '0;
            rep_armed_d = 1'b0;
        end else if (state_q == HELD && state_d == HELD) begin
            if (rep_q == (rep_armed_q ? PERIOD_LAST : DELAY_LAST)) begin
                rep_fire    = 1'b1;
                rep_d       = '0;
                rep_armed_d = 1'b1;
            end else begin
                rep_d = rep_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_q       <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_q       <= rep_d;
            rep_armed_q <= rep_armed_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pressed_q <= (state_d == HELD) || (state_d == RELEASE_WAIT);
            pulse_q   <= accept_press || rep_fire;
        end
    end

    assign pressed     = pressed_q;
    assign press_pulse = pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: expected pulse cycles are queued at stimulus time and matched by a monitor.
module tb_button_conditioner;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic clk = 1'b0;
    logic reset;
    logic button_raw;
    logic b1_raw;
    logic pressed, press_pulse;
    logic pressed1, press_pulse1;

    int cyc = 0;
    int n_checks = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp1_q[$];

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .ACTIVE_LOW      (1),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .button_raw  (button_raw),
        .pressed     (pressed),
        .press_pulse (press_pulse)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES (1),
        .ACTIVE_LOW      (1),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut1 (
        .clk         (clk),
        .reset       (reset),
        .button_raw  (b1_raw),
        .pressed     (pressed1),
        .press_pulse (press_pulse1)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // wait for the falling edge of cycle c
    task automatic to_neg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    // move to just after the rising edge that starts cycle c
    task automatic at_pos(input int c);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < c);
    endtask

    // scoreboard monitor: every pulse must match the head of its queue
    always @(negedge clk) begin
        while (exp_q.size() != 0 && exp_q[0] < cyc) begin
            check_val("missed_pulse", cyc, exp_q[0]);
            void'(exp_q.pop_front());
        end
        if (press_pulse === 1'b1) begin
            if (exp_q.size() != 0) check_val("pulse_cycle", cyc, exp_q.pop_front());
            else                   check_val("extra_pulse", press_pulse, 1'b0);
        end
        while (exp1_q.size() != 0 && exp1_q[0] < cyc) begin
            check_val("d1_missed_pulse", cyc, exp1_q[0]);
            void'(exp1_q.pop_front());
        end
        if (press_pulse1 === 1'b1) begin
            if (exp1_q.size() != 0) check_val("d1_pulse_cycle", cyc, exp1_q.pop_front());
            else                    check_val("d1_extra_pulse", press_pulse1, 1'b0);
        end
    end

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: got=timeout expected=finish (cycle %0d)", cyc);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p, r, f, e;
        logic pat [7];
        pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        // reset state
        reset = 1'b1;
        button_raw = 1'b1;
        b1_raw = 1'b1;
        at_pos(3);
        to_neg(cyc);
        check_val("rst_pressed", pressed, 1'b0);
        check_val("rst_pulse", press_pulse, 1'b0);
        check_val("rst_pressed_d1", pressed1, 1'b0);
        at_pos(cyc + 1);
        reset = 1'b0;
        at_pos(cyc + 5);

        // clean press and release
        p = cyc;
        button_raw = 1'b0;
        exp_q.push_back(p + 7);
        to_neg(p + 6); check_val("clean_pressed_before", pressed, 1'b0);
        to_neg(p + 7); check_val("clean_pressed_on", pressed, 1'b1);
        check_val("clean_pulse_on", press_pulse, 1'b1);
        to_neg(p + 8); check_val("clean_pulse_width", press_pulse, 1'b0);
        at_pos(p + 30);
        r = cyc;
        button_raw = 1'b1;
        to_neg(r + 6); check_val("clean_release_hold", pressed, 1'b1);
        to_neg(r + 7); check_val("clean_release_fall", pressed, 1'b0);
        at_pos(r + 12);
        check_val("clean_pending", exp_q.size(), 0);

        // bounce on press: never four stable lows
        for (int i = 0; i < 20; i++) begin
            button_raw = pat[i % 7];
            to_neg(cyc);
            check_val("bounce_pressed", pressed, 1'b0);
            at_pos(cyc + 1);
        end
        button_raw = 1'b1;
        at_pos(cyc + 10);
        to_neg(cyc);
        check_val("bounce_pressed_after", pressed, 1'b0);
        at_pos(cyc + 1);

        // bounce on release
        p = cyc;
        button_raw = 1'b0;
        exp_q.push_back(p + 7);
        at_pos(p + 20);
        r = cyc;
        button_raw = 1'b1;
        at_pos(r + 2); button_raw = 1'b0;
        at_pos(r + 3); button_raw = 1'b1;
        f = r + 3;
        to_neg(f + 6); check_val("rel_bounce_hold", pressed, 1'b1);
        to_neg(f + 7); check_val("rel_bounce_fall", pressed, 1'b0);
        at_pos(f + 15);
        check_val("rel_bounce_pending", exp_q.size(), 0);

        // reset in the middle of PRESS_WAIT, pin kept low
        p = cyc;
        button_raw = 1'b0;
        exp_q.push_back(p + 12);
        at_pos(p + 4);
        reset = 1'b1;
        at_pos(p + 5);
        reset = 1'b0;
        to_neg(p + 5);
        check_val("midrst_pressed", pressed, 1'b0);
        check_val("midrst_pulse", press_pulse, 1'b0);
        to_neg(p + 11); check_val("midrst_pressed_before", pressed, 1'b0);
        to_neg(p + 12); check_val("midrst_pressed_on", pressed, 1'b1);
        at_pos(p + 30);
        button_raw = 1'b1;
        at_pos(cyc + 15);
        check_val("midrst_pending", exp_q.size(), 0);

        // back-to-back presses
        p = cyc;
        button_raw = 1'b0;
        exp_q.push_back(p + 7);
        at_pos(p + 15);
        button_raw = 1'b1;
        to_neg(p + 24); check_val("b2b_gap_pressed", pressed, 1'b0);
        at_pos(p + 25);
        button_raw = 1'b0;
        exp_q.push_back(p + 32);
        to_neg(p + 33); check_val("b2b_second_pressed", pressed, 1'b1);
        at_pos(p + 40);
        button_raw = 1'b1;
        at_pos(cyc + 15);
        check_val("b2b_pending", exp_q.size(), 0);

        // long hold: repeat pulses only when the feature is built in
        p = cyc;
        e = p + 7;
        button_raw = 1'b0;
        exp_q.push_back(e);
`ifdef AUTO_REPEAT_EN
        exp_q.push_back(e + 20);
        exp_q.push_back(e + 28);
        exp_q.push_back(e + 36);
        exp_q.push_back(e + 44);
        exp_q.push_back(e + 52);
`endif
        at_pos(p + 60);
        button_raw = 1'b1;
        at_pos(cyc + 15);
        to_neg(cyc);
        check_val("hold_released", pressed, 1'b0);
        check_val("hold_pending", exp_q.size(), 0);
        at_pos(cyc + 1);

        // single-cycle debounce boundary
        p = cyc;
        b1_raw = 1'b0;
        exp1_q.push_back(p + 4);
        to_neg(p + 3); check_val("d1_pressed_before", pressed1, 1'b0);
        to_neg(p + 4); check_val("d1_pressed_on", pressed1, 1'b1);
        at_pos(p + 10);
        r = cyc;
        b1_raw = 1'b1;
        to_neg(r + 3); check_val("d1_release_hold", pressed1, 1'b1);
        to_neg(r + 4); check_val("d1_release_fall", pressed1, 1'b0);
        at_pos(r + 8);
        check_val("d1_pending", exp1_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
